level_sequencer: RTL and testbench
==================================

# level_sequencer

Top-level game sequencer for the loot field. It launches each level with a one-cycle `start_level` pulse and a stable `level_num`, then waits for the loot map to finish generating. During play it runs the per-level countdown from `start_of_frame` and accumulates score from caught loot. When time expires it decides win, loss or game completion.

## Interface
Parameters:
- `FRAMES_PER_SEC`, 60: `start_of_frame` pulses per countdown second.
- `LEVEL_TIME_SEC`, 60: seconds per level, range 1..127.
- `SETTLE_CYCLES`, 256: clocks held in SETTLE after launch, covering map generation.
- `BASE_TARGET`, 16'd500: target score for level 1.
- `TARGET_STEP`, 16'd400: target increment per further level.
- `MAX_LEVEL`, 3'd7: last playable level.

Ports:
- `clk`, in, 1: system clock.
- `resetN`, in, 1: asynchronous, active-low reset.
- `start_game`, in, 1: player button, level-sensitive. Rising edge is detected internally.
- `start_of_frame`, in, 1: one-cycle pulse per video frame.
- `caugth_loot_type`, in, 3: nonzero for exactly one cycle when the claw catches loot.
- `start_level`, out, 1: one-cycle launch pulse to the loot field.
- `level_num`, out, 3: current level, 1..MAX_LEVEL; 0 before the first launch.
- `score`, out, 16: cumulative score, saturating.
- `target`, out, 16: score required to pass the current level.
- `time_left`, out, 7: remaining seconds.
- `playing`, out, 1: high in PLAY only.
- `level_won`, out, 1: high in WON.
- `game_over`, out, 1: high in LOST or DONE.

## Operation
- States: IDLE, LAUNCH, SETTLE, PLAY, CHECK, WON, LOST, DONE.
- `go` is the registered rising edge of `start_game`: `start_game & ~start_game_d`.
- IDLE, on `go`:
  - `level_num`←1, `score`←0, `target`←BASE_TARGET.
  - Enter LAUNCH.
- LAUNCH (one cycle):
  - `start_level`=1.
  - `time_left`←LEVEL_TIME_SEC; frame counter←0; settle counter←0.
  - Enter SETTLE.
- SETTLE: count SETTLE_CYCLES clocks, then enter PLAY. Catches and frame pulses are ignored.
- PLAY, catches:
  - Nonzero `caugth_loot_type` adds its value: gold 100, rock 10, diamond 300, goblet 500.
  - Types 0 and 5..7 add 0.
  - Addition is 17-bit internally; the result saturates at 16'hFFFF.
- PLAY, countdown:
  - Each `start_of_frame` increments the frame counter.
  - When it reaches FRAMES_PER_SEC−1 and a pulse arrives, the counter wraps to 0 and `time_left` decrements.
  - When `time_left` goes 1→0, enter CHECK.
- CHECK (one cycle):
  - `score`≥`target` and `level_num`==MAX_LEVEL → DONE.
  - `score`≥`target` otherwise → WON.
  - Else → LOST.
- WON, on `go`:
  - `level_num`+1; `target`←`target`+TARGET_STEP, saturating.
  - Enter LAUNCH. `score` is kept.
- LOST and DONE, on `go`: same actions as IDLE on `go` (new game from level 1).
- Simultaneous events:
  - A catch on the same cycle as the final tick is counted.
  - Catches in CHECK, WON, LOST and DONE are dropped.
- `start_game` held high produces only one `go`.

## Timing
- Reset values of all outputs: `start_level`=0, `level_num`=0, `score`=0, `target`=BASE_TARGET, `time_left`=LEVEL_TIME_SEC, `playing`=`level_won`=`game_over`=0. State←IDLE, `start_game_d`←0.
- `go` is registered: `start_level` rises 2 clocks after `start_game` rises.
- `level_num` and `target` update on the edge entering LAUNCH, so both are valid during the `start_level` cycle and stable for the whole level.
- PLAY begins exactly SETTLE_CYCLES+1 clocks after the `start_level` cycle.
- Score updates 1 clock after the catch cycle.
- Flags are registered and decoded from the next state, so they change on the same edge as the state.
- Reset asserted mid-level returns every register to its reset value immediately. No `start_level` pulse is issued until the next `go`.

## Configuration
- `LEVEL_SEQ_TIME_BONUS_EN`
  - Defined: the transition CHECK→WON or CHECK→DONE adds `time_left`×10 to `score`, saturating. Because it is added at CHECK, the bonus is always 0 with the normal time-out exit, since `time_left` is 0 there.
  - Defined: the block gains an input `field_empty` (1 bit). In PLAY, `field_empty`=1 enters CHECK immediately, carrying the remaining time into the bonus.
  - Not defined: no `field_empty` port, no bonus. PLAY exits only on time-out.

## Structure
- Package `game_pkg`:
  - Loot type enum: NONE=0, GOLD=1, ROCK=2, DIAMOND=3, GOBLET=4.
  - Loot value constants.
  - `loot_value()` function, returning 16 bits.
  - State enum.
- Sub-module `frame_timer`: frame counter plus seconds countdown.
  - Inputs: `load`, `enable`, `start_of_frame`.
  - Outputs: `time_left`, one-cycle `expired`.
  - The sequencer drives `load` in LAUNCH and `enable` in PLAY.

## Test plan
Simulation parameters: FRAMES_PER_SEC=2, LEVEL_TIME_SEC=3, SETTLE_CYCLES=4.
- Reset, then raise `start_game` and hold it 10 clocks → exactly one `start_level` pulse; `level_num`=1 and `target`=500 during the pulse; `playing` rises 5 clocks later.
- In PLAY, catches of type 1, 3, 4, 2 → `score`=910 after the last catch; `time_left` goes 3→0 after 6 frame pulses; `level_won`=1.
- Level 1 with catches totalling only 490 at expiry → `game_over`=1. Next `go` → `level_num`=1, `score`=0.
- Catch of type 4 on the same cycle as the final frame pulse, with score 0 beforehand and target 500 → WON.
- Win levels 1..7 in sequence → `target`=500+6×400=2900 at level 7; after the win, DONE with `game_over`=1. Catch in DONE → score unchanged.
- Assert `resetN` low for one cycle during SETTLE → all outputs at their reset values; no further `start_level` pulse without `go`.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the loot-field game sequencer: loot types and values,
// sequencer states, saturating score arithmetic.
package game_pkg;

    localparam int unsigned SCORE_W = 16;
    localparam int unsigned TIME_W  = 7;
    localparam int unsigned LVL_W   = 3;
    localparam int unsigned LOOT_W  = 3;

    typedef enum logic [LOOT_W-1:0] {
        NONE    = 3'd0,
        GOLD    = 3'd1,
        ROCK    = 3'd2,
        DIAMOND = 3'd3,
        GOBLET  = 3'd4
    } loot_e;

    localparam logic [SCORE_W-1:0] GOLD_VALUE    = 16'd100;
    localparam logic [SCORE_W-1:0] ROCK_VALUE    = 16'd10;
    localparam logic [SCORE_W-1:0] DIAMOND_VALUE = 16'd300;
    localparam logic [SCORE_W-1:0] GOBLET_VALUE  = 16'd500;

    typedef enum logic [2:0] {
        IDLE, LAUNCH, SETTLE, PLAY, CHECK, WON, LOST, DONE
    } state_e;

    // Unknown loot codes (0, 5..7) are worth nothing.
    function automatic logic [SCORE_W-1:0] loot_value(input logic [LOOT_W-1:0] t);
        case (t)
            GOLD:    return GOLD_VALUE;
            ROCK:    return ROCK_VALUE;
            DIAMOND: return DIAMOND_VALUE;
            GOBLET:  return GOBLET_VALUE;
            default: return '0;
        endcase
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Player/field-facing signal bundle of the level sequencer.
// field_empty exists only when LEVEL_SEQ_TIME_BONUS_EN is defined.
interface level_sequencer_if;
    logic                         start_game;
    logic                         start_of_frame;
    logic [game_pkg::LOOT_W-1:0]  caugth_loot_type;
`ifdef LEVEL_SEQ_TIME_BONUS_EN
    logic                         field_empty;
`endif
    logic                         start_level;
    logic [game_pkg::LVL_W-1:0]   level_num;
    logic [game_pkg::SCORE_W-1:0] score;
    logic [game_pkg::SCORE_W-1:0] target;
    logic [game_pkg::TIME_W-1:0]  time_left;
    logic                         playing;
    logic                         level_won;
    logic                         game_over;

`ifdef LEVEL_SEQ_TIME_BONUS_EN
    modport master (output start_game, start_of_frame, caugth_loot_type, field_empty,
                    input  start_level, level_num, score, target, time_left,
                           playing, level_won, game_over);
    modport slave  (input  start_game, start_of_frame, caugth_loot_type, field_empty,
                    output start_level, level_num, score, target, time_left,
                           playing, level_won, game_over);
`else
    modport master (output start_game, start_of_frame, caugth_loot_type,
                    input  start_level, level_num, score, target, time_left,
                           playing, level_won, game_over);
    modport slave  (input  start_game, start_of_frame, caugth_loot_type,
                    output start_level, level_num, score, target, time_left,
                           playing, level_won, game_over);
`endif
endinterface

// File: rtl/frame_timer.sv
// Per-level countdown: divides start_of_frame pulses into seconds and counts time_left down.
// expired is a same-cycle strobe on the 1->0 tick so the sequencer leaves PLAY on that edge.
module frame_timer
    import game_pkg::*;
#(
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned LEVEL_TIME_SEC = 60
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              enable,
    input  logic              start_of_frame,
    output logic [TIME_W-1:0] time_left,
    output logic              expired
);

    localparam int unsigned FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

    logic [FC_W-1:0]   frame_q, frame_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              sec_tick_c;

    always_comb begin
        frame_d    = frame_q;
        time_d     = time_q;
        sec_tick_c = enable && start_of_frame && (frame_q == FC_W'(FRAMES_PER_SEC - 1));
        expired    = sec_tick_c && (time_q == TIME_W'(1));
        if (load) begin
            frame_d = '0;
            time_d  = TIME_W'(LEVEL_TIME_SEC);
        end else if (sec_tick_c) begin
            frame_d = '0;
            if (time_q != '0) time_d = time_q - TIME_W'(1);
        end else if (enable && start_of_frame) begin
            frame_d = frame_q + FC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            time_q  <= TIME_W'(LEVEL_TIME_SEC);
        end else begin
            frame_q <= frame_d;
            time_q  <= time_d;
        end
    end

    assign time_left = time_q;

endmodule

// File: rtl/level_sequencer.sv
// Game sequencer for the loot field: launches levels, times play, scores catches, decides outcome.
// Optional LEVEL_SEQ_TIME_BONUS_EN: field_empty early exit and remaining-time bonus on a pass.
module level_sequencer
    import game_pkg::*;
#(
    parameter int unsigned        FRAMES_PER_SEC = 60,
    parameter int unsigned        LEVEL_TIME_SEC = 60,
    parameter int unsigned        SETTLE_CYCLES  = 256,
    parameter logic [SCORE_W-1:0] BASE_TARGET    = 16'd500,
    parameter logic [SCORE_W-1:0] TARGET_STEP    = 16'd400,
    parameter logic [LVL_W-1:0]   MAX_LEVEL      = 3'd7
) (
    input  logic                 clk,
    input  logic                 resetN,
    level_sequencer_if.slave     bus
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

    state_e             state_q, state_d;
    logic               sg_q, sg_d;
    logic               go_q, go_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] target_q, target_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic               start_level_q, start_level_d;
    logic               playing_q, playing_d;
    logic               won_q, won_d;
    logic               over_q, over_d;
    logic [TIME_W-1:0]  time_left;
    logic               expired;
    logic               pass_c;
    logic               early_exit_c;

    frame_timer #(
        .FRAMES_PER_SEC (FRAMES_PER_SEC),
        .LEVEL_TIME_SEC (LEVEL_TIME_SEC)
    ) u_timer (
        .clk            (clk),
        .rst_n          (resetN),
        .load           (state_q == LAUNCH),
        .enable         (state_q == PLAY),
        .start_of_frame (bus.start_of_frame),
        .time_left      (time_left),
        .expired        (expired)
    );

    assign pass_c = (score_q >= target_q);
`ifdef LEVEL_SEQ_TIME_BONUS_EN
    assign early_exit_c = bus.field_empty;
`else
    assign early_exit_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WON, LOST, DONE: if (go_q) state_d = LAUNCH;
            LAUNCH: state_d = SETTLE;
            SETTLE: if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d = PLAY;
            PLAY:   if (expired || early_exit_c) state_d = CHECK;
            CHECK: begin
                if (pass_c && (level_q == MAX_LEVEL)) state_d = DONE;
                else if (pass_c)                      state_d = WON;
                else                                  state_d = LOST;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and flags; flags decode the next state so they move with it.
    always_comb begin
        sg_d          = bus.start_game;
        go_d          = bus.start_game & ~sg_q;
        level_d       = level_q;
        score_d       = score_q;
        target_d      = target_q;
        settle_d      = settle_q;
        start_level_d = (state_d == LAUNCH);
        playing_d     = (state_d == PLAY);
        won_d         = (state_d == WON);
        over_d        = (state_d == LOST) || (state_d == DONE);
        case (state_q)
            IDLE, LOST, DONE: if (go_q) begin
                level_d  = LVL_W'(1);
                score_d  = '0;
                target_d = BASE_TARGET;
            end
            WON: if (go_q) begin
                level_d  = level_q + LVL_W'(1);
                target_d = sat_add(target_q, TARGET_STEP);
            end
            LAUNCH: settle_d = '0;
            SETTLE: settle_d = settle_q + SET_W'(1);
            PLAY:   score_d  = sat_add(score_q, loot_value(bus.caugth_loot_type));
`ifdef LEVEL_SEQ_TIME_BONUS_EN
            CHECK:  if (pass_c) score_d = sat_add(score_q, SCORE_W'(time_left) * SCORE_W'(10));
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sg_q          <= 1'b0;
            go_q          <= 1'b0;
            level_q       <= '0;
            score_q       <= '0;
            target_q      <= BASE_TARGET;
            settle_q      <= '0;
            start_level_q <= 1'b0;
            playing_q     <= 1'b0;
            won_q         <= 1'b0;
            over_q        <= 1'b0;
        end else begin
            sg_q          <= sg_d;
            go_q          <= go_d;
            level_q       <= level_d;
            score_q       <= score_d;
            target_q      <= target_d;
            settle_q      <= settle_d;
            start_level_q <= start_level_d;
            playing_q     <= playing_d;
            won_q         <= won_d;
            over_q        <= over_d;
        end
    end

    assign bus.start_level = start_level_q;
    assign bus.level_num   = level_q;
    assign bus.score       = score_q;
    assign bus.target      = target_q;
    assign bus.time_left   = time_left;
    assign bus.playing     = playing_q;
    assign bus.level_won   = won_q;
    assign bus.game_over   = over_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed self-checking bench for level_sequencer (FRAMES_PER_SEC=2, LEVEL_TIME_SEC=3, SETTLE_CYCLES=4).
module tb_level_sequencer;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    level_sequencer_if bus();

    level_sequencer #(
        .FRAMES_PER_SEC (2),
        .LEVEL_TIME_SEC (3),
        .SETTLE_CYCLES  (4),
        .BASE_TARGET    (16'd500),
        .TARGET_STEP    (16'd400),
        .MAX_LEVEL      (3'd7)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int lvl_at_pulse, tgt_at_pulse, score_at_pulse;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_start_level"}, 32'(bus.start_level), 0);
        chk({pfx, "_level_num"},   32'(bus.level_num),   0);
        chk({pfx, "_score"},       32'(bus.score),       0);
        chk({pfx, "_target"},      32'(bus.target),      500);
        chk({pfx, "_time_left"},   32'(bus.time_left),   3);
        chk({pfx, "_playing"},     32'(bus.playing),     0);
        chk({pfx, "_level_won"},   32'(bus.level_won),   0);
        chk({pfx, "_game_over"},   32'(bus.game_over),   0);
    endtask

    task automatic press_go();
        bus.start_game = 1'b1;
        tick();
        bus.start_game = 1'b0;
    endtask

    task automatic wait_start();
        bit found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (bus.start_level) begin
                found          = 1'b1;
                lvl_at_pulse   = 32'(bus.level_num);
                tgt_at_pulse   = 32'(bus.target);
                score_at_pulse = 32'(bus.score);
            end
        end
        if (!found) chk("start_level_timeout", 0, 1);
    endtask

    task automatic wait_play();
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (bus.playing) found = 1'b1;
        end
        if (!found) chk("playing_timeout", 0, 1);
    endtask

    task automatic catch_loot(input logic [2:0] t);
        bus.caugth_loot_type = t;
        tick();
        bus.caugth_loot_type = 3'd0;
    endtask

    task automatic frame();
        bus.start_of_frame = 1'b1;
        tick();
        bus.start_of_frame = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, pulse_at, play_at, lvl1, tgt1;
        resetN               = 1'b1;
        bus.start_game       = 1'b0;
        bus.start_of_frame   = 1'b0;
        bus.caugth_loot_type = 3'd0;
`ifdef LEVEL_SEQ_TIME_BONUS_EN
        bus.field_empty      = 1'b0;
`endif
        #2 resetN = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        resetN = 1'b1;
        tick();

        // Held start_game gives one launch; PLAY five clocks after the pulse.
        pulses = 0; pulse_at = 0; play_at = 0; lvl1 = 0; tgt1 = 0;
        bus.start_game = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.start_level) begin
                pulses++;
                pulse_at = i;
                lvl1 = 32'(bus.level_num);
                tgt1 = 32'(bus.target);
            end
            if (bus.playing && play_at == 0) play_at = i;
        end
        bus.start_game = 1'b0;
        chk("launch_pulses", pulses, 1);
        chk("launch_latency", pulse_at, 2);
        chk("launch_level", lvl1, 1);
        chk("launch_target", tgt1, 500);
        chk("play_delay", play_at - pulse_at, 5);

        // Catches 1,3,4,2 -> 910, then countdown to a win.
        catch_loot(3'd1);
        chk("score_gold", 32'(bus.score), 100);
        catch_loot(3'd3);
        chk("score_diamond", 32'(bus.score), 400);
        catch_loot(3'd4);
        catch_loot(3'd2);
        chk("score_910", 32'(bus.score), 910);
        frame(); frame();
        chk("time_after_2", 32'(bus.time_left), 2);
        frame(); frame();
        chk("time_after_4", 32'(bus.time_left), 1);
        chk("still_playing", 32'(bus.playing), 1);
        frame(); frame();
        chk("time_after_6", 32'(bus.time_left), 0);
        chk("won_l1", 32'(bus.level_won), 1);
        chk("won_l1_playing", 32'(bus.playing), 0);
        chk("won_l1_over", 32'(bus.game_over), 0);

        // Fresh game; 490 at expiry is a loss.
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        press_go(); wait_start(); wait_play();
        catch_loot(3'd3); catch_loot(3'd1); catch_loot(3'd5); catch_loot(3'd0);
        for (int i = 0; i < 9; i++) catch_loot(3'd2);
        chk("score_490", 32'(bus.score), 490);
        for (int i = 0; i < 6; i++) frame();
        chk("lost_over", 32'(bus.game_over), 1);
        chk("lost_won", 32'(bus.level_won), 0);
        press_go(); wait_start();
        chk("restart_level", lvl_at_pulse, 1);
        chk("restart_score", score_at_pulse, 0);
        wait_play();

        // Goblet on the final frame pulse is counted.
        for (int i = 0; i < 5; i++) frame();
        bus.start_of_frame   = 1'b1;
        bus.caugth_loot_type = 3'd4;
        tick();
        bus.start_of_frame   = 1'b0;
        bus.caugth_loot_type = 3'd0;
        tick();
        chk("final_tick_score", 32'(bus.score), 500);
        chk("final_tick_won", 32'(bus.level_won), 1);

        // Levels 2..7, one goblet each; level 7 ends the game.
        for (int l = 2; l <= 7; l++) begin
            press_go(); wait_start();
            chk("lvl_num", lvl_at_pulse, l);
            chk("lvl_target", tgt_at_pulse, 500 + 400 * (l - 1));
            wait_play();
            catch_loot(3'd4);
            for (int i = 0; i < 6; i++) frame();
            chk("lvl_score", 32'(bus.score), 500 * l);
            if (l < 7) chk("lvl_won", 32'(bus.level_won), 1);
        end
        chk("done_over", 32'(bus.game_over), 1);
        chk("done_won", 32'(bus.level_won), 0);
        chk("done_target", 32'(bus.target), 2900);
        catch_loot(3'd4);
        chk("done_catch_dropped", 32'(bus.score), 3500);

        // Reset in SETTLE: everything back to reset values, no relaunch without go.
        press_go(); wait_start();
        tick(); tick();
        resetN = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        tick();
        resetN = 1'b1;
        pulses = 0; play_at = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.start_level) pulses++;
            if (bus.playing) play_at++;
        end
        chk("post_rst_pulses", pulses, 0);
        chk("post_rst_playing", play_at, 0);
        check_reset_vals("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
